axi4_csr_bank: RTL



---
 rtl/csr_bank_pkg.sv | 19 +
 rtl/csr_bank_reg.sv | 50 +++++
 rtl/axi4_csr_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bank_pkg.sv
// Shared encodings for the AXI4 CSR bank: FSM states and AXI response codes.
package csr_bank_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/csr_bank_reg.sv
// One CSR cell: byte-strobed RW, write-1-to-clear with hardware set, or read-only.
module csr_bank_reg
    import csr_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit RO     = 1'b0,
    parameter bit W1C    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   ro_val_i,
    input  logic [DATA_W-1:0]   hw_set_i,
    output logic [DATA_W-1:0]   q_o
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] bmask;

    always_comb begin
        bmask = '0;
        for (int j = 0; j < DATA_W/8; j++) begin
            bmask[j*8 +: 8] = {8{wstrb_i[j]}};
        end
    end

    // Hardware set is applied after the clear so a simultaneous set wins.
    always_comb begin
        q_d = q_q;
        if (RO) begin
            q_d = '0;
        end else if (W1C) begin
            if (we_i) q_d = q_q & ~(wdata_i & bmask);
            q_d = q_d | hw_set_i;
        end else if (we_i) begin
            q_d = (q_q & ~bmask) | (wdata_i & bmask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = RO ? ro_val_i : q_q;

endmodule

// File: rtl/axi4_csr_bank.sv
// AXI4 slave register bank with INCR bursts, RO and W1C registers.
module axi4_csr_bank
    import csr_bank_pkg::*;
#(
    parameter int                     ADDR_W           = 32,
    parameter logic [ADDR_W-1:0]      BASE_ADDR        = 32'h4000_0000,
    parameter int                     REG_NUM          = 8,
    parameter int                     DATA_W           = 32,
    parameter int                     MST_ID_W         = 5,
    parameter int                     TRANS_DATA_LEN_W = 8,
    parameter int                     TRANS_RESP_W     = 2,
    parameter logic [REG_NUM-1:0]     RO_MASK          = '0,
    parameter logic [REG_NUM-1:0]     W1C_MASK         = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MST_ID_W-1:0]           m_awid_i,
    input  logic [ADDR_W-1:0]             m_awaddr_i,
    input  logic [TRANS_DATA_LEN_W-1:0]   m_awlen_i,
    input  logic                          m_awvalid_i,
    output logic                          m_awready_o,
    input  logic [DATA_W-1:0]             m_wdata_i,
    input  logic [DATA_W/8-1:0]           m_wstrb_i,
    input  logic                          m_wlast_i,
    input  logic                          m_wvalid_i,
    output logic                          m_wready_o,
    output logic [MST_ID_W-1:0]           m_bid_o,
    output logic [TRANS_RESP_W-1:0]       m_bresp_o,
    output logic                          m_bvalid_o,
    input  logic                          m_bready_i,
    input  logic [MST_ID_W-1:0]           m_arid_i,
    input  logic [ADDR_W-1:0]             m_araddr_i,
    input  logic [TRANS_DATA_LEN_W-1:0]   m_arlen_i,
    input  logic                          m_arvalid_i,
    output logic                          m_arready_o,
    output logic [MST_ID_W-1:0]           m_rid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic [TRANS_RESP_W-1:0]       m_rresp_o,
    output logic                          m_rlast_o,
    output logic                          m_rvalid_o,
    input  logic                          m_rready_i,
    output logic [REG_NUM*DATA_W-1:0]     reg_o,
    input  logic [REG_NUM*DATA_W-1:0]     ro_val_i,
    input  logic [REG_NUM*DATA_W-1:0]     hw_set_i,
    output logic [REG_NUM-1:0]            wr_pulse_o
);

    localparam int OFFSET  = DATA_W / 8;
    localparam int OFF_LSB = $clog2(OFFSET);
    localparam int IDX_W   = $clog2(REG_NUM);
    localparam int LEN_W   = TRANS_DATA_LEN_W;
    localparam logic [ADDR_W-1:0] WIN  = ADDR_W'(REG_NUM * OFFSET);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(OFFSET);

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < WIN) && (off[OFF_LSB-1:0] == '0);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[OFF_LSB +: IDX_W];
    endfunction

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [REG_NUM-1:0] ro_m;
    assign ro_m = RO_MASK;

    // ---------------- write path ----------------
    wr_state_t           w_state_q, w_state_d;
    logic [MST_ID_W-1:0] awid_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [LEN_W-1:0]    wlen_q, wcnt_q;
    logic [1:0]          bresp_q, beat_resp;
    logic [REG_NUM-1:0]  we, wr_pulse_q;
    logic                aw_hs, w_hs, w_hit, w_last;
    logic [IDX_W-1:0]    w_idx;

    assign m_awready_o = (w_state_q == W_IDLE);
    assign m_wready_o  = (w_state_q == W_DATA);
    assign m_bvalid_o  = (w_state_q == W_RESP);
    assign m_bid_o     = awid_q;
    assign m_bresp_o   = TRANS_RESP_W'(bresp_q);
    assign wr_pulse_o  = wr_pulse_q;

    assign aw_hs  = m_awvalid_i & m_awready_o;
    assign w_hs   = m_wvalid_i & m_wready_o;
    assign w_hit  = hit(waddr_q);
    assign w_idx  = idx(waddr_q);
    assign w_last = (wcnt_q == wlen_q);

    always_comb begin
        w_state_d = w_state_q;
        beat_resp = RESP_OKAY;
        we        = '0;
        if (!w_hit) begin
            beat_resp = RESP_DECERR;
        end else if (ro_m[w_idx] || (m_wlast_i != w_last)) begin
            beat_resp = RESP_SLVERR;
        end
        if (w_hs && w_hit && !ro_m[w_idx]) we[w_idx] = 1'b1;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_last) w_state_d = W_RESP;
            W_RESP:  if (m_bready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Response codes are ordered so the numerically larger one has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            awid_q     <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            wr_pulse_q <= we;
            if (aw_hs) begin
                awid_q  <= m_awid_i;
                waddr_q <= m_awaddr_i;
                wlen_q  <= m_awlen_i;
                wcnt_q  <= '0;
                bresp_q <= RESP_OKAY;
            end else if (w_hs) begin
                waddr_q <= waddr_q + STEP;
                wcnt_q  <= wcnt_q + 1'b1;
                if (beat_resp > bresp_q) bresp_q <= beat_resp;
            end
        end
    end

    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
        csr_bank_reg #(
            .DATA_W (DATA_W),
            .RO     (RO_MASK[i]),
            .W1C    (W1C_MASK[i])
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .we_i     (we[i]),
            .wdata_i  (m_wdata_i),
            .wstrb_i  (m_wstrb_i),
            .ro_val_i (ro_val_i[i*DATA_W +: DATA_W]),
            .hw_set_i (hw_set_i[i*DATA_W +: DATA_W]),
            .q_o      (regs[i])
        );
        assign reg_o[i*DATA_W +: DATA_W] = regs[i];
    end

    // ---------------- read path ----------------
    rd_state_t           r_state_q, r_state_d;
    logic [MST_ID_W-1:0] rid_q;
    logic [ADDR_W-1:0]   raddr_q, ld_addr;
    logic [LEN_W-1:0]    rlen_q, rcnt_q;
    logic [DATA_W-1:0]   rdata_q, ld_data;
    logic [1:0]          rresp_q, ld_resp;
    logic                ar_hs, r_hs, r_last, ld_hit;

    assign m_arready_o = (r_state_q == R_IDLE);
    assign m_rvalid_o  = (r_state_q == R_DATA);
    assign m_rlast_o   = m_rvalid_o & r_last;
    assign m_rid_o     = rid_q;
    assign m_rdata_o   = rdata_q;
    assign m_rresp_o   = TRANS_RESP_W'(rresp_q);

    assign ar_hs  = m_arvalid_i & m_arready_o;
    assign r_hs   = m_rvalid_o & m_rready_i;
    assign r_last = (rcnt_q == rlen_q);

    // One decoder serves both the first beat and every following beat.
    always_comb begin
        ld_addr = (r_state_q == R_IDLE) ? m_araddr_i : raddr_q + STEP;
        ld_hit  = hit(ld_addr);
        ld_data = ld_hit ? regs[idx(ld_addr)] : '0;
        ld_resp = ld_hit ? RESP_OKAY : RESP_DECERR;
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                rid_q   <= m_arid_i;
                raddr_q <= m_araddr_i;
                rlen_q  <= m_arlen_i;
                rcnt_q  <= '0;
                rdata_q <= ld_data;
                rresp_q <= ld_resp;
            end else if (r_hs && !r_last) begin
                raddr_q <= ld_addr;
                rcnt_q  <= rcnt_q + 1'b1;
                rdata_q <= ld_data;
                rresp_q <= ld_resp;
            end
        end
    end

endmodule
